vram_fetch_fifo: RTL and testbench

//  Requester on one 32-bit read-only port (addr/strobe/ack) of the VRAM arbiter. Fetches a run of

---
 rtl/vram_fetch_fifo.sv | 104 ++++++++++
 tb/tb_vram_fetch_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_fifo.sv
// Streams a run of consecutive 32-bit VRAM words through one arbiter read port
// into a small show-ahead FIFO that feeds the renderer over valid/ready.
module vram_fetch_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [14:0]           start_addr,
    input  logic [LEN_W-1:0]      word_count,
    output logic                  busy,
    output logic                  done,
    output logic [14:0]           vram_addr,
    output logic                  vram_strobe,
    input  logic                  vram_ack,
    input  logic [31:0]           vram_rddata,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fill_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [DEPTH-1:0][31:0] mem_q;
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]          count_q, count_d, count_n;
    logic [14:0]            addr_q, addr_d;
    logic [LEN_W-1:0]       remain_q, remain_d, remain_n;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   ack, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // An ack is ignored in a start cycle (it belongs to the old run) and while
    // idle (trailing grant after rst).
    assign ack = vram_ack & ~start & busy_q;
    assign pop = out_ready & (count_q != '0) & ~start;

    assign remain_n = remain_q - LEN_W'(ack);
    assign count_n  = count_q + CW'(ack) - CW'(pop);

    // Address already advanced past a word being acked this cycle, so a
    // granted strobe is never repeated; one grant at most is ever in flight.
    assign vram_addr   = addr_q + 15'(ack);
    assign vram_strobe = busy_q & ~start & (remain_n != '0) & (count_n < CW'(DEPTH));

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_data   = mem_q[rd_q];
    assign out_valid  = (count_q != '0);
    assign fill_level = count_q;

    always_comb begin
        addr_d   = vram_addr;
        remain_d = remain_n;
        count_d  = count_n;
        wr_d     = ack ? ptr_inc(wr_q) : wr_q;
        rd_d     = pop ? ptr_inc(rd_q) : rd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (ack && remain_q == LEN_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (start) begin
            addr_d   = start_addr;
            remain_d = word_count;
            count_d  = '0;
            wr_d     = '0;
            rd_d     = '0;
            busy_d   = (word_count != '0);
            done_d   = (word_count == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            count_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ack) mem_q[wr_q] <= vram_rddata;
    end
endmodule

// File: tb/tb_vram_fetch_fifo.sv
// Directed bench: behavioural arbiter/VRAM model plus a queue scoreboard of
// expected words, checked as the consumer pops them.
module tb_vram_fetch_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] start_addr = '0;
    logic [7:0]  word_count = '0;
    logic        busy, done, vram_strobe, out_valid;
    logic [14:0] vram_addr;
    logic        vram_ack = 1'b0;
    logic [31:0] vram_rddata = '0;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [2:0]  fill_level;

    vram_fetch_fifo #(.DEPTH_LOG2(2), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .vram_addr(vram_addr), .vram_strobe(vram_strobe), .vram_ack(vram_ack),
        .vram_rddata(vram_rddata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gmode = 0, scnt = 0, nacks = 0, ndone = 0, npops = 0;
    logic [31:0] q[$];
    int gcount[int];

    function automatic logic [31:0] mdata(input logic [14:0] a);
        return {17'h1A5A5, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample pops/acks/done, decide the arbiter grant, then present
    // the registered ack and read data after the edge.
    task automatic tick();
        logic        g;
        logic [14:0] ga;
        logic [31:0] e;
        #1;
        if (vram_ack) nacks++;
        if (done) ndone++;
        if (out_valid && out_ready && !start && !rst) begin
            e = (q.size() != 0) ? q.pop_front() : 32'hDEADBEEF;
            npops++;
            chk("pop_data", out_data, e);
        end
        g  = 1'b0;
        ga = vram_addr;
        if (vram_strobe) begin
            g    = (gmode == 0) || (gmode == 1 && scnt == 2);
            scnt = (scnt == 2) ? 0 : scnt + 1;
            if (g) begin
                if (gcount.exists(int'(ga))) gcount[int'(ga)] = gcount[int'(ga)] + 1;
                else gcount[int'(ga)] = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        vram_ack    = g;
        vram_rddata = g ? mdata(ga) : 32'hBAD0BAD0;
    endtask

    task automatic do_start(input logic [14:0] a, input logic [7:0] n);
        logic [14:0] t;
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        q.delete();
        for (int i = 0; i < int'(n); i++) begin
            t = a + 15'(i);
            q.push_back(mdata(t));
        end
        #1;
        chk("start_no_strobe", 32'(vram_strobe), 32'd0);
        tick();
        start = 1'b0;
        nacks = 0; ndone = 0; npops = 0; scnt = 0;
        gcount.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] wa;
        // reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobe", 32'(vram_strobe), 0);
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_fill", 32'(fill_level), 0);

        // 1: uncontended run
        gmode = 0; out_ready = 1'b1;
        do_start(15'h0100, 8'd4);
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk("t1_strobe", 32'(vram_strobe), 32'(c <= 4));
            if (c <= 4) chk("t1_addr", 32'(vram_addr), 32'(15'h0100 + 15'(c - 1)));
            chk("t1_done", 32'(done), 32'(c == 6));
            chk("t1_busy", 32'(busy), 32'(c <= 5));
            tick();
        end
        chk("t1_acks", nacks, 4);
        chk("t1_pops", npops, 4);
        chk("t1_sb_empty", q.size(), 0);

        // 2: backpressure
        out_ready = 1'b0;
        do_start(15'h0300, 8'd8);
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("t2_acks_full", nacks, 4);
        chk("t2_fill", 32'(fill_level), 4);
        chk("t2_strobe_off", 32'(vram_strobe), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!busy && !out_valid && q.size() == 0) break;
            tick();
        end
        chk("t2_acks", nacks, 8);
        chk("t2_pops", npops, 8);
        chk("t2_sb_empty", q.size(), 0);

        // 3: contention with address wrap
        gmode = 1;
        do_start(15'h7FFE, 8'd4);
        for (int i = 0; i < 60; i++) begin
            if (!busy && !out_valid && q.size() == 0) break;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            wa = 15'h7FFE + 15'(i);
            chk("t3_grant_once", gcount.exists(int'(wa)) ? gcount[int'(wa)] : 0, 1);
        end
        chk("t3_grant_addrs", gcount.num(), 4);
        chk("t3_pops", npops, 4);
        chk("t3_done", ndone, 1);

        // 4: restart mid-run while an ack is arriving
        gmode = 0;
        do_start(15'h0200, 8'd16);
        for (int i = 0; i < 4; i++) tick();
        do_start(15'h0400, 8'd2);
        #1;
        chk("t4_flushed", 32'(fill_level), 0);
        chk("t4_valid", 32'(out_valid), 0);
        for (int i = 0; i < 12; i++) tick();
        chk("t4_acks", nacks, 2);
        chk("t4_pops", npops, 2);
        chk("t4_done", ndone, 1);
        chk("t4_sb_empty", q.size(), 0);

        // 5: empty run
        do_start(15'h0123, 8'd0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("t5_strobe", 32'(vram_strobe), 0);
            chk("t5_busy", 32'(busy), 0);
            chk("t5_done", 32'(done), 32'(c == 1));
            tick();
        end

        // 6: reset with a grant in flight
        out_ready = 1'b0;
        do_start(15'h0500, 8'd8);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t6_strobe_pre", 32'(vram_strobe), 1);
        tick();
        rst = 1'b0;
        q.delete();
        #1;
        chk("t6_ack_pending", 32'(vram_ack), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_strobe", 32'(vram_strobe), 0);
        chk("t6_addr", 32'(vram_addr), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_fill", 32'(fill_level), 0);
        tick();
        #1;
        chk("t6_fill_after", 32'(fill_level), 0);
        chk("t6_valid_after", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
